throw_path_driver: RTL and testbench
====================================

# throw_path_driver

Hardware bus initiator for the sprite video slot. It takes a one-shot throw command (start position, velocity, colour) and animates a ballistic path by issuing register writes on the slot's write-only bus once per frame, during vertical blank. It updates sprite origin, animation control and bypass. It sits between the frame counter and the sprite slot, replacing per-frame CPU writes for thrown objects.

## Interface
- TRIG_Y, 480: frame-counter row that marks the update point (start of vertical blank)
- GROUND_Y, 448: landing row for sprite origin y0
- H_MAX, 639: rightmost legal x0
- GRAV, 1: added to vy each frame
- VY_MAX, 15: vy saturation limit (positive, downward)
- ANIM_DIV, 4: frames per animation-frame increment
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- x, y  in  11  frame counter (pixel position)
- start  in  1  single-cycle command pulse; accepted only when busy=0
- x_init, y_init  in  11  start origin, unsigned
- vx_init, vy_init  in  8  signed velocity, pixels/frame
- color  in  2  animation colour select, goes to ctrl[4:3]
- abort  in  1  single-cycle pulse; ends the throw early
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse when the hide write completes
- cs, write  out  1 each  slot bus strobes, always equal
- addr  out  14  slot address
- wr_data  out  32  slot write data

## Operation
- Slot register map is fixed. Bit 13 set selects registers.
  - 0x2000 bypass: data bit 0.
  - 0x2001 x0: data[10:0].
  - 0x2002 y0: data[10:0].
  - 0x2003 ctrl: data[4:0] = {color, anim[2:0]}.
- Unused wr_data bits are zero.
- Internal state:
  - x_pos, y_pos: signed 12-bit.
  - vx: signed 8-bit.
  - vy: signed 8-bit.
  - anim: 3-bit wrapping counter.
  - div_cnt: counts 0..ANIM_DIV-1.
- Frame tick: a registered edge detect of (x==0 && y==TRIG_Y). This yields exactly one tick per frame regardless of pixel-clock ratio.
- FSM states and transitions:
  - IDLE: on start, latch all inputs, clear anim and div_cnt, go to W_X0.
  - W_X0 → W_Y0 → W_CTRL → W_SHOW: one write per cycle. W_SHOW writes bypass=0. These states are used only on launch.
  - WAIT: on tick, go to UPDATE.
  - UPDATE: one cycle, computes the next position.
    - x_n = x_pos + sext(vx).
    - y_n = y_pos + vy, using the old vy.
    - vy = min(vy + GRAV, VY_MAX).
    - div_cnt advances; at wrap, anim increments (mod 8).
  - UPDATE branches on x_n and y_n:
    - If x_n < 0 or x_n > H_MAX: go to W_HIDE, with no position write.
    - Else if y_n >= GROUND_Y: set y_pos = GROUND_Y, set land flag, go to U_X0.
    - Else: y_pos = max(y_n, 0), go to U_X0.
  - U_X0 → U_Y0 → U_CTRL: then go to W_HIDE if land is set, else WAIT.
  - W_HIDE: writes bypass=1, then go to DONE.
  - DONE: done=1 for one cycle, then IDLE.
- abort while busy:
  - The current write completes.
  - The next state is W_HIDE.
  - abort arriving during W_HIDE or DONE is ignored.
- A tick outside WAIT is latched in a pending flag and consumed on the next entry to WAIT. At most one tick is pending.
- start while busy is ignored.

## Timing
- All outputs are registered.
- Reset values: cs=write=0, addr=0, wr_data=0, busy=0, done=0. The FSM goes to IDLE. No hide write is issued on reset, including mid-throw.
- Each write asserts cs/write for exactly one cycle, with addr and wr_data valid in the same cycle.
- Writes within a sequence are back-to-back. Outside writes, cs=0 and addr/wr_data=0.
- start at cycle N gives busy=1 at N+1 and the first write (x0) at N+1. Launch writes occur at N+1..N+4.
- Tick detected at cycle T gives UPDATE at T+1 and writes at T+2..T+4.
- Hide write occurs the cycle after the last position write, or T+2 for off-screen exit.
- done is high the cycle after the hide write. busy falls with done.

## Structure
- Shared package throw_pkg holds:
  - the state enum;
  - slot address constants (ADDR_BYPASS, ADDR_X0, ADDR_Y0, ADDR_CTRL);
  - ctrl field positions.
- No sub-module. Tick edge detect and bus register live inline.
- Instantiated beside the sprite slot. Its cs/write/addr/wr_data are muxed with the CPU slot bus by the parent.

## Test plan
- Launch (100,200), vx=3, vy=-4, color=2: cycles N+1..N+4 write 0x2001←100, 0x2002←200, 0x2003←0x10, 0x2000←0. busy=1 from N+1.
- Gravity path, same launch, 3 ticks: y0 writes are 196, 193, 191 and x0 writes are 103, 106, 109. ctrl anim reads 0x10, 0x10, 0x10; the 4th tick gives ctrl 0x11.
- Landing from y=440, vy=10: first tick writes y0=448, then 0x2000←1, then a done pulse, then busy=0.
- Right exit from x=637, vx=5: tick gives no position write; 0x2000←1 at T+2 and done at T+3.
- abort during U_Y0: U_Y0 write completes, next cycle writes 0x2000←1 with no ctrl write, then done. reset low mid-flight: next cycle cs=0, busy=0, no hide write.
- start pulsed while busy, and x==0 held for 4 clocks at y==TRIG_Y: start is ignored, and exactly one UPDATE occurs per frame.

Source files
------------

// File: rtl/throw_pkg.sv
// throw_pkg: shared state encoding, slot register map and word builders for
// throw_path_driver.
package throw_pkg;

    localparam int unsigned ADDR_W  = 14;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned COORD_W = 11;
    localparam int unsigned POS_W   = 12;
    localparam int unsigned VEL_W   = 8;
    localparam int unsigned ANIM_W  = 3;
    localparam int unsigned COLOR_W = 2;

    // Slot register map (bit 13 selects the register space).
    localparam logic [ADDR_W-1:0] ADDR_BYPASS = 14'h2000;
    localparam logic [ADDR_W-1:0] ADDR_X0     = 14'h2001;
    localparam logic [ADDR_W-1:0] ADDR_Y0     = 14'h2002;
    localparam logic [ADDR_W-1:0] ADDR_CTRL   = 14'h2003;

    // ctrl register field positions: {color, anim}.
    localparam int unsigned CTRL_ANIM_LSB  = 0;
    localparam int unsigned CTRL_COLOR_LSB = 3;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_W_X0,
        ST_W_Y0,
        ST_W_CTRL,
        ST_W_SHOW,
        ST_WAIT,
        ST_UPDATE,
        ST_U_X0,
        ST_U_Y0,
        ST_U_CTRL,
        ST_W_HIDE,
        ST_DONE
    } state_t;

    // Coordinate register word: value in the low bits, rest zero.
    function automatic logic [DATA_W-1:0] coord_word(input logic [COORD_W-1:0] c);
        return DATA_W'(c);
    endfunction

    // ctrl register word with unused bits zero.
    function automatic logic [DATA_W-1:0] ctrl_word(input logic [COLOR_W-1:0] color,
                                                    input logic [ANIM_W-1:0]  anim);
        logic [DATA_W-1:0] w;
        w = '0;
        w[CTRL_COLOR_LSB +: COLOR_W] = color;
        w[CTRL_ANIM_LSB  +: ANIM_W]  = anim;
        return w;
    endfunction

endpackage

// File: rtl/throw_path_driver.sv
// throw_path_driver: animates a thrown sprite by issuing one burst of slot
// register writes per frame (at start of vertical blank).
//
// Ports:
//   clk, reset        clock, synchronous active-low reset
//   x, y              frame counter position
//   start             one-cycle launch command (ignored while busy)
//   x_init, y_init    launch origin
//   vx_init, vy_init  signed launch velocity (pixels/frame)
//   color             animation colour for ctrl[4:3]
//   abort             one-cycle pulse ending the throw early
//   busy, done        throw in progress / one-cycle completion pulse
//   cs, write         slot bus strobes (always equal)
//   addr, wr_data     slot bus address and data
import throw_pkg::*;

module throw_path_driver #(
    parameter int unsigned TRIG_Y   = 480,
    parameter int unsigned GROUND_Y = 448,
    parameter int unsigned H_MAX    = 639,
    parameter int unsigned GRAV     = 1,
    parameter int unsigned VY_MAX   = 15,
    parameter int unsigned ANIM_DIV = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [COORD_W-1:0]  x,
    input  logic [COORD_W-1:0]  y,
    input  logic                start,
    input  logic [COORD_W-1:0]  x_init,
    input  logic [COORD_W-1:0]  y_init,
    input  logic [VEL_W-1:0]    vx_init,
    input  logic [VEL_W-1:0]    vy_init,
    input  logic [COLOR_W-1:0]  color,
    input  logic                abort,
    output logic                busy,
    output logic                done,
    output logic                cs,
    output logic                write,
    output logic [ADDR_W-1:0]   addr,
    output logic [DATA_W-1:0]   wr_data
);

    localparam int unsigned DIV_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

    state_t                    state;
    logic signed [POS_W-1:0]   x_pos;
    logic signed [POS_W-1:0]   y_pos;
    logic signed [VEL_W-1:0]   vx;
    logic signed [VEL_W-1:0]   vy;
    logic [ANIM_W-1:0]         anim;
    logic [DIV_W-1:0]          div_cnt;
    logic [COLOR_W-1:0]        color_q;
    logic                      land;
    logic                      pending;
    logic                      hit_q;
    logic                      tick;

    logic                      hit;
    logic                      abortable;
    logic signed [POS_W-1:0]   x_n;
    logic signed [POS_W-1:0]   y_n;
    logic signed [POS_W-1:0]   y_clip;
    logic signed [VEL_W:0]     vy_inc;
    logic signed [VEL_W-1:0]   vy_n;
    logic                      off_screen;
    logic                      grounded;
    logic                      div_wrap;

    assign hit       = (x == '0) && (y == COORD_W'(TRIG_Y));
    assign abortable = state inside {ST_W_X0, ST_W_Y0, ST_W_CTRL, ST_W_SHOW, ST_WAIT,
                                     ST_UPDATE, ST_U_X0, ST_U_Y0, ST_U_CTRL};

    // Next-frame kinematics; vy is widened one bit so saturation cannot wrap.
    always_comb begin
        x_n        = x_pos + {{(POS_W-VEL_W){vx[VEL_W-1]}}, vx};
        y_n        = y_pos + {{(POS_W-VEL_W){vy[VEL_W-1]}}, vy};
        vy_inc     = {vy[VEL_W-1], vy} + (VEL_W+1)'(GRAV);
        vy_n       = (vy_inc > $signed((VEL_W+1)'(VY_MAX))) ? VEL_W'(VY_MAX)
                                                             : vy_inc[VEL_W-1:0];
        off_screen = x_n[POS_W-1] || (x_n > $signed(POS_W'(H_MAX)));
        grounded   = (y_n >= $signed(POS_W'(GROUND_Y)));
        y_clip     = y_n[POS_W-1] ? '0 : y_n;
        div_wrap   = (div_cnt == DIV_W'(ANIM_DIV - 1));
    end

    // Control FSM; bus registers are loaded with the write of the state being entered.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= ST_IDLE;
            x_pos   <= '0;
            y_pos   <= '0;
            vx      <= '0;
            vy      <= '0;
            anim    <= '0;
            div_cnt <= '0;
            color_q <= '0;
            land    <= 1'b0;
            pending <= 1'b0;
            hit_q   <= 1'b0;
            tick    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            cs      <= 1'b0;
            write   <= 1'b0;
            addr    <= '0;
            wr_data <= '0;
        end else begin
            hit_q   <= hit;
            tick    <= hit & ~hit_q;
            cs      <= 1'b0;
            write   <= 1'b0;
            addr    <= '0;
            wr_data <= '0;
            done    <= 1'b0;

            // Remember a frame tick that arrives while mid-sequence.
            if (tick && (state != ST_IDLE) && (state != ST_WAIT)) begin
                pending <= 1'b1;
            end

            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        x_pos   <= POS_W'(x_init);
                        y_pos   <= POS_W'(y_init);
                        vx      <= vx_init;
                        vy      <= vy_init;
                        color_q <= color;
                        anim    <= '0;
                        div_cnt <= '0;
                        land    <= 1'b0;
                        busy    <= 1'b1;
                        state   <= ST_W_X0;
                        cs      <= 1'b1;
                        write   <= 1'b1;
                        addr    <= ADDR_X0;
                        wr_data <= coord_word(x_init);
                    end
                end
                ST_W_X0: begin
                    state   <= ST_W_Y0;
                    cs      <= 1'b1;
                    write   <= 1'b1;
                    addr    <= ADDR_Y0;
                    wr_data <= coord_word(y_pos[COORD_W-1:0]);
                end
                ST_W_Y0: begin
                    state   <= ST_W_CTRL;
                    cs      <= 1'b1;
                    write   <= 1'b1;
                    addr    <= ADDR_CTRL;
                    wr_data <= ctrl_word(color_q, anim);
                end
                ST_W_CTRL: begin
                    state   <= ST_W_SHOW;
                    cs      <= 1'b1;
                    write   <= 1'b1;
                    addr    <= ADDR_BYPASS;
                    wr_data <= '0;
                end
                ST_W_SHOW: begin
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (tick || pending) begin
                        pending <= 1'b0;
                        state   <= ST_UPDATE;
                    end
                end
                ST_UPDATE: begin
                    vy      <= vy_n;
                    div_cnt <= div_wrap ? '0 : div_cnt + DIV_W'(1);
                    if (div_wrap) begin
                        anim <= anim + ANIM_W'(1);
                    end
                    cs    <= 1'b1;
                    write <= 1'b1;
                    if (off_screen) begin
                        state   <= ST_W_HIDE;
                        addr    <= ADDR_BYPASS;
                        wr_data <= DATA_W'(1);
                    end else begin
                        x_pos <= x_n;
                        if (grounded) begin
                            y_pos <= POS_W'(GROUND_Y);
                            land  <= 1'b1;
                        end else begin
                            y_pos <= y_clip;
                        end
                        state   <= ST_U_X0;
                        addr    <= ADDR_X0;
                        wr_data <= coord_word(x_n[COORD_W-1:0]);
                    end
                end
                ST_U_X0: begin
                    state   <= ST_U_Y0;
                    cs      <= 1'b1;
                    write   <= 1'b1;
                    addr    <= ADDR_Y0;
                    wr_data <= coord_word(y_pos[COORD_W-1:0]);
                end
                ST_U_Y0: begin
                    state   <= ST_U_CTRL;
                    cs      <= 1'b1;
                    write   <= 1'b1;
                    addr    <= ADDR_CTRL;
                    wr_data <= ctrl_word(color_q, anim);
                end
                ST_U_CTRL: begin
                    if (land) begin
                        state   <= ST_W_HIDE;
                        cs      <= 1'b1;
                        write   <= 1'b1;
                        addr    <= ADDR_BYPASS;
                        wr_data <= DATA_W'(1);
                    end else begin
                        state <= ST_WAIT;
                    end
                end
                ST_W_HIDE: begin
                    state <= ST_DONE;
                    done  <= 1'b1;
                end
                ST_DONE: begin
                    state   <= ST_IDLE;
                    busy    <= 1'b0;
                    pending <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase

            // Abort lets the write on the bus finish, then hides the sprite next.
            if (abort && abortable) begin
                state   <= ST_W_HIDE;
                cs      <= 1'b1;
                write   <= 1'b1;
                addr    <= ADDR_BYPASS;
                wr_data <= DATA_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_throw_path_driver.sv
// tb_throw_path_driver: directed and randomized throws checked against a
// frame-level ballistic model of the expected slot writes and done pulses.
`timescale 1ns/1ps
module tb_throw_path_driver;

    localparam int TRIG_Y   = 480;
    localparam int GROUND_Y = 448;
    localparam int H_MAX    = 639;
    localparam int GRAV     = 1;
    localparam int VY_MAX   = 15;
    localparam int ANIM_DIV = 4;

    localparam logic [13:0] A_BYP  = 14'h2000;
    localparam logic [13:0] A_X0   = 14'h2001;
    localparam logic [13:0] A_Y0   = 14'h2002;
    localparam logic [13:0] A_CTRL = 14'h2003;
    localparam logic [13:0] A_DONE = 14'h3fff;   // marker for a done pulse event

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [10:0] x = 11'd5;
    logic [10:0] y = 11'd0;
    logic        start = 1'b0;
    logic [10:0] x_init = '0;
    logic [10:0] y_init = '0;
    logic [7:0]  vx_init = '0;
    logic [7:0]  vy_init = '0;
    logic [1:0]  color = '0;
    logic        abort = 1'b0;
    logic        busy;
    logic        done;
    logic        cs;
    logic        write;
    logic [13:0] addr;
    logic [31:0] wr_data;

    throw_path_driver dut (
        .clk     (clk),
        .reset   (reset),
        .x       (x),
        .y       (y),
        .start   (start),
        .x_init  (x_init),
        .y_init  (y_init),
        .vx_init (vx_init),
        .vy_init (vy_init),
        .color   (color),
        .abort   (abort),
        .busy    (busy),
        .done    (done),
        .cs      (cs),
        .write   (write),
        .addr    (addr),
        .wr_data (wr_data)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] cyc;
        logic [13:0] addr;
        logic [31:0] data;
    } ev_t;

    ev_t aq[$];
    ev_t eq[$];
    int  checks = 0;
    int  failures = 0;
    int unsigned cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h cyc=%0d", tag, got, exp, cyc);
        end
    endtask

    // Bus monitor: records every write and done pulse with its cycle number.
    always @(negedge clk) begin
        if (cs || write) begin
            check("strobe", 32'(write), 32'(cs));
            aq.push_back({32'(cyc), addr, wr_data});
        end else begin
            check("idle_bus", 32'(addr) | wr_data, 32'd0);
        end
        if (done) aq.push_back({32'(cyc), A_DONE, 32'd0});
    end

    // Frame-level model of a throw.
    int m_x, m_y, m_vx, m_vy, m_color, m_frames;
    bit m_active;

    function automatic void push(input int unsigned c, input logic [13:0] a, input int d);
        eq.push_back({32'(c), a, 32'(d)});
    endfunction

    function automatic void model_launch(input int unsigned l, input int xi, input int yi,
                                         input int vxi, input int vyi, input int ci);
        m_x = xi; m_y = yi; m_vx = vxi; m_vy = vyi; m_color = ci;
        m_frames = 0; m_active = 1'b1;
        push(l,     A_X0,   xi);
        push(l + 1, A_Y0,   yi);
        push(l + 2, A_CTRL, ci * 8);
        push(l + 3, A_BYP,  0);
    endfunction

    function automatic void model_frame(input int unsigned t);
        int nx, ny, anim;
        bit landed;
        m_frames++;
        nx   = m_x + m_vx;
        ny   = m_y + m_vy;
        m_vy = (m_vy + GRAV > VY_MAX) ? VY_MAX : m_vy + GRAV;
        anim = (m_frames / ANIM_DIV) % 8;
        if (nx < 0 || nx > H_MAX) begin
            push(t + 2, A_BYP, 1);
            push(t + 3, A_DONE, 0);
            m_active = 1'b0;
        end else begin
            landed = (ny >= GROUND_Y);
            m_x = nx;
            m_y = landed ? GROUND_Y : ((ny < 0) ? 0 : ny);
            push(t + 2, A_X0,   m_x);
            push(t + 3, A_Y0,   m_y);
            push(t + 4, A_CTRL, m_color * 8 + anim);
            if (landed) begin
                push(t + 5, A_BYP, 1);
                push(t + 6, A_DONE, 0);
                m_active = 1'b0;
            end
        end
    endfunction

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge; returns at the negedge of the first write cycle.
    task automatic launch(input int xi, input int yi, input int vxi, input int vyi,
                          input int ci, output int unsigned l);
        start   = 1'b1;
        x_init  = 11'(xi);
        y_init  = 11'(yi);
        vx_init = 8'(vxi);
        vy_init = 8'(vyi);
        color   = 2'(ci);
        @(negedge clk);
        start = 1'b0;
        l = cyc;
    endtask

    // Holds the trigger position for n clocks; returns the tick cycle.
    task automatic tick_hold(input int n, output int unsigned t);
        x = 11'd0;
        y = 11'(TRIG_Y);
        @(negedge clk);
        t = cyc;
        repeat (n - 1) @(negedge clk);
        x = 11'd5;
        y = 11'd0;
    endtask

    task automatic poke_start();
        start   = 1'b1;
        x_init  = 11'd7;
        y_init  = 11'd9;
        vx_init = 8'd1;
        vy_init = 8'd1;
        color   = 2'd3;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic do_abort();
        int unsigned a;
        a = cyc;
        push(a + 1, A_BYP, 1);
        push(a + 2, A_DONE, 0);
        m_active = 1'b0;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("idle_wait", 32'(busy), 32'd0);
    endtask

    task automatic check_events(input string tag);
        int n;
        check({tag, "_count"}, 32'(aq.size()), 32'(eq.size()));
        n = (aq.size() < eq.size()) ? aq.size() : eq.size();
        for (int i = 0; i < n; i++) begin
            check({tag, "_cyc"},  aq[i].cyc,        eq[i].cyc);
            check({tag, "_addr"}, 32'(aq[i].addr),  32'(eq[i].addr));
            check({tag, "_data"}, aq[i].data,       eq[i].data);
        end
        aq.delete();
        eq.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    int unsigned l_c, t_c, t2_c;
    int xi, yi, vxi, vyi, ci;

    initial begin
        // Reset state
        step(3);
        check("rst_cs",    32'(cs),    32'd0);
        check("rst_write", 32'(write), 32'd0);
        check("rst_addr",  32'(addr),  32'd0);
        check("rst_data",  wr_data,    32'd0);
        check("rst_busy",  32'(busy),  32'd0);
        check("rst_done",  32'(done),  32'd0);
        reset = 1'b1;
        step(2);
        aq.delete();

        // Launch and gravity path over four frames
        launch(100, 200, 3, -4, 2, l_c);
        check("launch_busy", 32'(busy), 32'd1);
        model_launch(l_c, 100, 200, 3, -4, 2);
        step(5);
        check_events("launch");
        check("launch_busy_wait", 32'(busy), 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick_hold(1, t_c);
            model_frame(t_c);
            step(8);
            check_events("grav");
        end
        do_abort();
        wait_idle(20);
        check_events("grav_abort");

        // Landing
        launch(300, 440, 0, 10, 1, l_c);
        model_launch(l_c, 300, 440, 0, 10, 1);
        step(5);
        check_events("land_launch");
        tick_hold(1, t_c);
        model_frame(t_c);
        step(6);
        check("land_done",    32'(done), 32'd1);
        check("land_busy_hi", 32'(busy), 32'd1);
        step(1);
        check("land_busy_lo", 32'(busy), 32'd0);
        check("land_done_lo", 32'(done), 32'd0);
        check_events("land");

        // Right-edge exit
        launch(637, 100, 5, 0, 0, l_c);
        model_launch(l_c, 637, 100, 5, 0, 0);
        step(5);
        check_events("exit_launch");
        tick_hold(1, t_c);
        model_frame(t_c);
        step(3);
        check("exit_done", 32'(done), 32'd1);
        step(1);
        check("exit_busy_lo", 32'(busy), 32'd0);
        check_events("exit");

        // Abort during the y0 update write
        launch(50, 100, 4, -2, 3, l_c);
        model_launch(l_c, 50, 100, 4, -2, 3);
        step(5);
        check_events("abort_launch");
        tick_hold(1, t_c);
        model_frame(t_c);
        void'(eq.pop_back());
        step(3);
        do_abort();
        wait_idle(20);
        check_events("abort_uy0");

        // Reset mid-flight: no hide write, bus and busy drop
        launch(200, 100, 2, -3, 0, l_c);
        step(5);
        tick_hold(1, t_c);
        step(3);
        reset = 1'b0;
        @(negedge clk);
        check("midrst_cs",   32'(cs),   32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        reset = 1'b1;
        aq.delete();
        eq.delete();
        m_active = 1'b0;
        step(10);
        check("midrst_quiet", 32'(aq.size()), 32'd0);

        // Tick during launch is held pending; start while busy ignored;
        // trigger held for 4 clocks yields one update.
        launch(320, 240, -2, -6, 1, l_c);
        model_launch(l_c, 320, 240, -2, -6, 1);
        tick_hold(1, t2_c);
        model_frame(l_c + 4);
        poke_start();
        step(10);
        poke_start();
        step(2);
        tick_hold(4, t_c);
        model_frame(t_c);
        step(10);
        check_events("pend_hold");
        do_abort();
        wait_idle(20);
        check_events("pend_abort");

        // Randomized throws
        for (int t = 0; t < 8; t++) begin
            xi  = int'($urandom_range(639));
            yi  = int'($urandom_range(447));
            vxi = int'($urandom_range(40)) - 20;
            vyi = int'($urandom_range(30)) - 15;
            ci  = int'($urandom_range(3));
            launch(xi, yi, vxi, vyi, ci, l_c);
            model_launch(l_c, xi, yi, vxi, vyi, ci);
            step(6);
            for (int f = 0; f < 25 && m_active; f++) begin
                tick_hold(1, t_c);
                model_frame(t_c);
                step(int'($urandom_range(10, 7)));
                if (m_active && $urandom_range(3) == 0) begin
                    poke_start();
                    step(1);
                end
            end
            if (m_active) begin
                step(2);
                do_abort();
            end
            wait_idle(40);
            step(1);
            check_events("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
